// File: rtl/yutorina_dmac_pkg.sv
// Shared definitions for the yutorina DMA controller: register map, CTRL bit
// positions, bus direction encodings and master FSM state encodings.
package yutorina_dmac_pkg;

    // Width of the transfer word counter
    localparam int unsigned DMAC_COUNT_W = 16;

    // Bus slave select assigned to the DMAC register window
    localparam logic [2:0] DmacAddrLocale = 3'h5;

    // Register indices within the slave window
    localparam logic [1:0] DMAC_CTRL  = 2'd0;
    localparam logic [1:0] DMAC_SRC   = 2'd1;
    localparam logic [1:0] DMAC_DST   = 2'd2;
    localparam logic [1:0] DMAC_COUNT = 2'd3;

    // CTRL bit positions
    localparam int unsigned DMAC_CTRL_START = 0;
    localparam int unsigned DMAC_CTRL_IE    = 1;
    localparam int unsigned DMAC_CTRL_DONE  = 2;

    // Bus direction encodings
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Master FSM states
    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StReq  = 3'd1,
        StRd   = 3'd2,
        StWr   = 3'd3,
        StNext = 3'd4,
        StDone = 3'd5
    } dmac_state_e;

endpackage

// File: rtl/yutorina_dmac.sv
// Single-channel memory-to-memory DMA controller: a four-register slave window
// programmed by the CPU and a bus master that copies COUNT words SRC -> DST.
module yutorina_dmac
    import yutorina_dmac_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned COUNT_W = DMAC_COUNT_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // Slave register window
    input  logic              i_cs_,
    input  logic              i_s_as_,
    input  logic [1:0]        i_s_addr,
    input  logic              i_s_rw,
    input  logic [DATA_W-1:0] i_s_w_data,
    output logic [DATA_W-1:0] o_s_r_data,
    output logic              o_s_rdy_,
    // Bus master
    output logic              o_m_req_,
    input  logic              i_m_grnt_,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic              o_m_as_,
    output logic              o_m_rw,
    output logic [DATA_W-1:0] o_m_w_data,
    input  logic [DATA_W-1:0] i_m_r_data,
    input  logic              i_m_rdy_,
    // Completion interrupt
    output logic              o_int
);

    dmac_state_e         r_state;
    dmac_state_e         w_state_d;
    logic                r_busy;
    logic                r_ie;
    logic                r_done;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [COUNT_W-1:0]  r_count;
    logic [DATA_W-1:0]   r_buf;
    // Read half of the current word is done; a regrant resumes at the write
    logic                r_have_data;
    logic                r_s_rdy_;
    logic [DATA_W-1:0]   r_s_r_data;
    logic [DATA_W-1:0]   w_rd_data;
    logic                w_acc;
    logic                w_wr;
    logic                w_unused_wdata;

    assign w_acc          = ~i_cs_ & ~i_s_as_;
    assign w_wr           = w_acc & (i_s_rw == WRITE);
    assign w_unused_wdata = ^i_s_w_data[DATA_W-1:ADDR_W];

    assign o_s_rdy_   = r_s_rdy_;
    assign o_s_r_data = r_s_r_data;
    assign o_int      = r_done & r_ie;

    // Register read multiplexer; unused bits read as zero
    always_comb begin
        w_rd_data = '0;
        unique case (i_s_addr)
            DMAC_CTRL: begin
                w_rd_data[DMAC_CTRL_START] = r_busy;
                w_rd_data[DMAC_CTRL_IE]    = r_ie;
                w_rd_data[DMAC_CTRL_DONE]  = r_done;
            end
            DMAC_SRC:   w_rd_data[ADDR_W-1:0]  = r_src;
            DMAC_DST:   w_rd_data[ADDR_W-1:0]  = r_dst;
            DMAC_COUNT: w_rd_data[COUNT_W-1:0] = r_count;
            default:    w_rd_data = '0;
        endcase
    end

    // Slave response, CPU register writes and FSM-side register updates
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s_rdy_    <= 1'b1;
            r_s_r_data  <= '0;
            r_busy      <= 1'b0;
            r_ie        <= 1'b0;
            r_done      <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_count     <= '0;
            r_buf       <= '0;
            r_have_data <= 1'b0;
        end else begin
            r_s_rdy_   <= ~w_acc;
            r_s_r_data <= (w_acc && i_s_rw == READ) ? w_rd_data : '0;

            if (w_wr) begin
                unique case (i_s_addr)
                    DMAC_CTRL: begin
                        r_ie <= i_s_w_data[DMAC_CTRL_IE];
                        if (i_s_w_data[DMAC_CTRL_DONE]) begin
                            r_done <= 1'b0;
                        end
                        if (!r_busy && i_s_w_data[DMAC_CTRL_START]) begin
                            r_busy <= 1'b1;
                        end
                    end
                    DMAC_SRC:   if (!r_busy) r_src <= i_s_w_data[ADDR_W-1:0];
                    DMAC_DST:   if (!r_busy) r_dst <= i_s_w_data[ADDR_W-1:0];
                    DMAC_COUNT: if (!r_busy) r_count <= i_s_w_data[COUNT_W-1:0];
                    default: ;
                endcase
            end

            // Hardware updates come last so a DONE set beats a same-cycle CPU clear
            if (r_state == StIdle && r_busy && r_count == '0) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (r_state == StRd && !i_m_rdy_) begin
                r_buf       <= i_m_r_data;
                r_have_data <= 1'b1;
            end
            if (r_state == StWr && !i_m_rdy_) begin
                r_have_data <= 1'b0;
            end
            if (r_state == StNext) begin
                r_src   <= r_src + 1'b1;
                r_dst   <= r_dst + 1'b1;
                r_count <= r_count - 1'b1;
            end
            if (r_state == StDone) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // FSM next state and bus master outputs
    always_comb begin
        w_state_d  = r_state;
        o_m_req_   = 1'b1;
        o_m_as_    = 1'b1;
        o_m_rw     = READ;
        o_m_addr   = '0;
        o_m_w_data = '0;
        unique case (r_state)
            StIdle: begin
                if (r_busy && r_count != '0) begin
                    w_state_d = StReq;
                end
            end
            StReq: begin
                o_m_req_ = 1'b0;
                if (!i_m_grnt_) begin
                    w_state_d = r_have_data ? StWr : StRd;
                end
            end
            StRd: begin
                o_m_req_ = 1'b0;
                o_m_as_  = 1'b0;
                o_m_rw   = READ;
                o_m_addr = r_src;
                if (!i_m_rdy_) begin
                    w_state_d = i_m_grnt_ ? StReq : StWr;
                end
            end
            StWr: begin
                o_m_req_   = 1'b0;
                o_m_as_    = 1'b0;
                o_m_rw     = WRITE;
                o_m_addr   = r_dst;
                o_m_w_data = r_buf;
                if (!i_m_rdy_) begin
                    w_state_d = StNext;
                end
            end
            StNext: begin
                // Bus stays requested across the whole burst
                o_m_req_ = 1'b0;
                if (r_count == COUNT_W'(1)) begin
                    w_state_d = StDone;
                end else if (i_m_grnt_) begin
                    w_state_d = StReq;
                end else begin
                    w_state_d = StRd;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

endmodule
